// File: rtl/mod_counter_div.sv
// rtl/mod_counter_div.sv - programmable modulo counter with terminal-count pulse and divided output
module mod_counter_div #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             div_out
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             div_nxt;

    // Terminal conditions for each direction; compares avoid any overflow past max_val.
    logic up_term;
    logic dn_above;
    logic dn_term;

    assign up_term  = (count >= max_val);
    assign dn_above = (count > max_val);
    assign dn_term  = (count == ZERO);

    // Next-state selection: load beats enable, enable beats hold; tc only survives one step.
    always_comb begin
        count_nxt = count;
        tc_nxt    = 1'b0;
        div_nxt   = div_out;
        if (load) begin
            count_nxt = (load_val > max_val) ? max_val : load_val;
        end else if (en) begin
            if (up) begin
                if (up_term) begin
                    tc_nxt = 1'b1;
                    if (SATURATE) begin
                        count_nxt = max_val;
                    end else begin
                        count_nxt = ZERO;
                        div_nxt   = ~div_out;
                    end
                end else begin
                    count_nxt = count + ONE;
                end
            end else begin
                if (dn_above) begin
                    // Out-of-range after max_val was lowered: snap back into range quietly.
                    count_nxt = max_val;
                end else if (dn_term) begin
                    tc_nxt = 1'b1;
                    if (SATURATE) begin
                        count_nxt = ZERO;
                    end else begin
                        count_nxt = max_val;
                        div_nxt   = ~div_out;
                    end
                end else begin
                    count_nxt = count - ONE;
                end
            end
        end
    end

    // Output registers; every output is a flop so downstream logic sees no input glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= ZERO;
            tc      <= 1'b0;
            div_out <= 1'b0;
        end else begin
            count   <= count_nxt;
            tc      <= tc_nxt;
            div_out <= div_nxt;
        end
    end

endmodule

// File: tb/tb_mod_counter_div.sv
// tb/tb_mod_counter_div.sv - randomized and directed bench for mod_counter_div
module tb_mod_counter_div;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;
    logic [7:0] max_val = '0;

    logic [7:0] cnt [2];
    logic       tcv [2];
    logic       div [2];

    int checks = 0;
    int passed = 0;

    int m_c [2];
    bit m_tc [2];
    bit m_div [2];

    always #5 clk = ~clk;

    mod_counter_div #(.WIDTH(8), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .max_val(max_val),
        .count(cnt[0]), .tc(tcv[0]), .div_out(div[0])
    );

    mod_counter_div #(.WIDTH(8), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .max_val(max_val),
        .count(cnt[1]), .tc(tcv[1]), .div_out(div[1])
    );

    // Reference: the counter's rules written with plain integers.
    task automatic model_step(input int k);
        int lv;
        int mv;
        lv = int'(load_val);
        mv = int'(max_val);
        if (rst) begin
            m_c[k] = 0; m_tc[k] = 0; m_div[k] = 0;
        end else if (load) begin
            m_c[k] = (lv < mv) ? lv : mv;
            m_tc[k] = 0;
        end else if (en && up) begin
            if (m_c[k] < mv) begin
                m_c[k] = m_c[k] + 1; m_tc[k] = 0;
            end else begin
                m_tc[k] = 1;
                if (k == 1) m_c[k] = mv;
                else begin m_c[k] = 0; m_div[k] = !m_div[k]; end
            end
        end else if (en) begin
            if (m_c[k] > mv) begin
                m_c[k] = mv; m_tc[k] = 0;
            end else if (m_c[k] > 0) begin
                m_c[k] = m_c[k] - 1; m_tc[k] = 0;
            end else begin
                m_tc[k] = 1;
                if (k == 0) begin m_c[k] = mv; m_div[k] = !m_div[k]; end
            end
        end else begin
            m_tc[k] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        m_c[0] = 0; m_c[1] = 0; m_tc = '{0, 0}; m_div = '{0, 0};
        rst = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({cnt[k], tcv[k], div[k]} !== 10'b0)
                $display("FAIL reset_init inst%0d: count=%0d tc=%0b div=%0b, expected all 0", k, cnt[k], tcv[k], div[k]);
            else passed++;
        end
        rst = 1'b0; max_val = 8'd9; up = 1'b1; en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (cnt[0] !== 8'd5) $display("FAIL reset_precount: count=%0d, expected 5", cnt[0]);
        else passed++;
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({cnt[k], tcv[k], div[k]} !== 10'b0)
                $display("FAIL reset_async inst%0d: count=%0d tc=%0b div=%0b, expected all 0", k, cnt[k], tcv[k], div[k]);
            else passed++;
        end
        @(negedge clk);
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            m_c[k] = 0; m_tc[k] = 0; m_div[k] = 0;
            checks++;
            if ({cnt[k], tcv[k], div[k]} !== 10'b0)
                $display("FAIL reset_hold inst%0d: count=%0d tc=%0b div=%0b, expected all 0", k, cnt[k], tcv[k], div[k]);
            else passed++;
        end
        rst = 1'b0; en = 1'b0;
    endtask

    task automatic test_wrap_up();
        int exp_c;
        bit exp_d;
        do_reset();
        max_val = 8'd4; up = 1'b1; en = 1'b1;
        exp_d = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp_c = i % 5;
            if (exp_c == 0) exp_d = !exp_d;
            checks++;
            if (cnt[0] !== 8'(exp_c) || tcv[0] !== (exp_c == 0) || div[0] !== exp_d)
                $display("FAIL wrap_up cycle%0d: count=%0d tc=%0b div=%0b, expected count=%0d tc=%0b div=%0b",
                         i, cnt[0], tcv[0], div[0], exp_c, exp_c == 0, exp_d);
            else passed++;
        end
        en = 1'b0;
    endtask

    task automatic test_wrap_down();
        int seq [10] = '{4, 3, 2, 1, 0, 4, 3, 2, 1, 0};
        do_reset();
        max_val = 8'd4; up = 1'b0; en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (cnt[0] !== 8'(seq[i]) || tcv[0] !== (seq[i] == 4) || cnt[1] !== 8'd0 || tcv[1] !== 1'b1)
                $display("FAIL wrap_down step%0d: count=%0d tc=%0b sat_count=%0d sat_tc=%0b, expected count=%0d tc=%0b sat_count=0 sat_tc=1",
                         i, cnt[0], tcv[0], cnt[1], tcv[1], seq[i], seq[i] == 4);
            else passed++;
        end
        en = 1'b0;
    endtask

    task automatic test_saturate();
        int seq [6] = '{1, 2, 3, 3, 3, 3};
        do_reset();
        max_val = 8'd3; up = 1'b1; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (cnt[1] !== 8'(seq[i]) || tcv[1] !== (i >= 3) || div[1] !== 1'b0)
                $display("FAIL saturate step%0d: count=%0d tc=%0b div=%0b, expected count=%0d tc=%0b div=0",
                         i, cnt[1], tcv[1], div[1], seq[i], i >= 3);
            else passed++;
        end
        en = 1'b0;
    endtask

    task automatic test_load();
        bit d0;
        do_reset();
        max_val = 8'd9; load_val = 8'd2; load = 1'b1;
        tick();
        load_val = 8'd12; en = 1'b1; up = 1'b1;
        tick();
        checks++;
        if (cnt[0] !== 8'd9 || tcv[0] !== 1'b0)
            $display("FAIL load_clamp: count=%0d tc=%0b, expected count=9 tc=0", cnt[0], tcv[0]);
        else passed++;
        d0 = div[0];
        load = 1'b0;
        tick();
        checks++;
        if (cnt[0] !== 8'd0 || tcv[0] !== 1'b1 || div[0] !== !d0 || cnt[1] !== 8'd9 || tcv[1] !== 1'b1)
            $display("FAIL load_then_up: count=%0d tc=%0b div=%0b sat_count=%0d sat_tc=%0b, expected 0 1 %0b 9 1",
                     cnt[0], tcv[0], div[0], cnt[1], tcv[1], !d0);
        else passed++;
        en = 1'b0;
    endtask

    task automatic test_max_change();
        bit d0;
        do_reset();
        max_val = 8'd9; load_val = 8'd7; load = 1'b1;
        tick();
        load = 1'b0; max_val = 8'd3; en = 1'b1; up = 1'b1;
        d0 = div[0];
        tick();
        checks++;
        if (cnt[0] !== 8'd0 || tcv[0] !== 1'b1 || div[0] !== !d0)
            $display("FAIL lower_max_up: count=%0d tc=%0b div=%0b, expected 0 1 %0b", cnt[0], tcv[0], div[0], !d0);
        else passed++;
        max_val = 8'd9; load = 1'b1;
        tick();
        load = 1'b0; max_val = 8'd3; up = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (cnt[k] !== 8'd3 || tcv[k] !== 1'b0)
                $display("FAIL lower_max_down inst%0d: count=%0d tc=%0b, expected 3 0", k, cnt[k], tcv[k]);
            else passed++;
        end
        max_val = 8'd0; up = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            d0 = div[0];
            tick();
            checks++;
            if (cnt[0] !== 8'd0 || tcv[0] !== 1'b1 || div[0] !== !d0 || tcv[1] !== 1'b1)
                $display("FAIL max_zero cycle%0d: count=%0d tc=%0b div=%0b sat_tc=%0b, expected 0 1 %0b 1",
                         i, cnt[0], tcv[0], div[0], tcv[1], !d0);
            else passed++;
        end
        en = 1'b0;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 9) < 8);
            up = $urandom_range(0, 1);
            load = ($urandom_range(0, 19) == 0);
            load_val = 8'($urandom);
            if ($urandom_range(0, 15) == 0) max_val = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (cnt[k] !== 8'(m_c[k]) || tcv[k] !== m_tc[k] || div[k] !== m_div[k]) begin
                    errs++;
                    if (errs <= 10)
                        $display("FAIL random cycle%0d inst%0d: count=%0d tc=%0b div=%0b, expected count=%0d tc=%0b div=%0b",
                                 i, k, cnt[k], tcv[k], div[k], m_c[k], m_tc[k], m_div[k]);
                end else passed++;
            end
        end
        en = 1'b0; load = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_load();
        test_max_change();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mod_counter_div.md
Name: mod_counter_div

Overview:
Parametrised, programmable modulo counter and clock divider. It generalises the fixed 3-bit toggle counter and divide-by-8 divider to WIDTH bits. It adds run-time modulus, up/down direction, synchronous load, count enable, wrap or saturate mode, a terminal-count pulse and a toggling divided output. It is used as the timebase or event counter feeding display and debounce logic.

Parameters:
WIDTH, 8, counter and modulus width in bits (>=2)
SATURATE, 0, 0 = wrap at terminal, 1 = hold at terminal

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  asynchronous active-high reset
en  input  1  count enable; a step occurs only on edges where en=1
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous load strobe, overrides en
load_val  input  WIDTH  value loaded when load=1
max_val  input  WIDTH  modulus-1; count range is 0..max_val
count  output  WIDTH  current count, registered
tc  output  1  terminal-count pulse, registered
div_out  output  1  divided output, toggles on every wrap event

Behaviour:
- Reset: one clock and one asynchronous active-high reset, clk and rst. rst=1 forces count=0, tc=0 and div_out=0 immediately, independent of clk. State holds while rst=1. The first step happens on the first rising edge after rst deasserts.
- Priority per edge: rst > load > en > hold.
- Load (load=1):
  - count <= min(load_val, max_val).
  - tc <= 0; div_out unchanged; en and up ignored.
- Enabled up step (en=1, up=1, load=0):
  - count < max_val: count <= count+1, tc <= 0.
  - count >= max_val and SATURATE=0: count <= 0, tc <= 1, div_out <= ~div_out (wrap event).
  - count >= max_val and SATURATE=1: count <= max_val, tc <= 1, div_out unchanged.
- Enabled down step (en=1, up=0, load=0):
  - count > max_val: count <= max_val, tc <= 0. This covers an out-of-range count after max_val is lowered.
  - 0 < count <= max_val: count <= count-1, tc <= 0.
  - count == 0 and SATURATE=0: count <= max_val, tc <= 1, div_out <= ~div_out (wrap event).
  - count == 0 and SATURATE=1: count stays 0, tc <= 1, div_out unchanged.
- Idle (en=0, load=0): count and div_out hold; tc <= 0. tc is therefore a single-cycle pulse per terminal step, never stretched by idle cycles.
- Latency:
  - count reflects a step one edge after the enabling edge.
  - tc and div_out update on the same edge as the terminal step. tc is high during the cycle in which count shows the wrapped value (0 for up, max_val for down).
- Divide ratio:
  - With en=1 constantly, SATURATE=0 and a fixed direction, tc period = max_val+1 cycles.
  - div_out period = 2*(max_val+1) cycles at 50% duty.
- max_val=0:
  - count is pinned at 0.
  - Every enabled step is a terminal step, so tc stays high while en=1.
  - In wrap mode div_out toggles every enabled cycle (divide-by-2).
- max_val may change at any time and takes effect on the next edge, with no glitch on outputs.
- Arithmetic is unsigned WIDTH-bit. No intermediate overflow is permitted: the up-step compare uses >=, so count never reaches 2^WIDTH.
- Direction may change between any two edges. The terminal condition is evaluated for the direction in effect on that edge.
- All outputs come straight from flops; none is combinational from inputs.

Test Plan:
1. WIDTH=8, SATURATE=0, rst pulse mid-count (count=5) -> count, tc and div_out go to 0 before the next clk edge and stay 0 until rst falls.
2. max_val=4, en=1, up=1 for 20 cycles from reset -> count 1,2,3,4,0,1,...; tc high exactly in the cycles count=0 (cycles 5,10,15,20); div_out toggles at each, giving a period of 10 cycles.
3. max_val=4, up=0, en=1 from count=0 -> count 4,3,2,1,0,4,...; tc high on every transition to 4, including the first step.
4. SATURATE=1, max_val=3, up=1, en=1 for 6 cycles -> count 1,2,3,3,3,3; tc=1 on the cycles after the 4th, 5th and 6th edges; div_out stays 0.
5. count=2, max_val=9, assert load=1 and en=1 with load_val=12 -> count=9 (clamped), tc=0. Next edge up -> count=0, tc=1.
6. count=7, max_val lowered from 9 to 3, then up step -> count=0, tc=1, div_out toggles. Repeat with a down step from count=7 -> count=3, tc=0. With max_val=0 and en=1 -> tc held 1, div_out toggles every cycle.
